// File: rtl/cache_refill_if.sv
// Miss-path refill bus: miss request, memory burst read, SRAM write port, forward and completion.
interface cache_refill_if #(
  parameter int unsigned ADDR_WIDTH = 30,
  parameter int unsigned NUM_WAYS   = 4
);
  localparam int unsigned WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  logic                  miss_vld_i;
  logic                  miss_rdy_o;
  logic [ADDR_WIDTH-1:0] miss_addr_i;
  logic [WAY_W-1:0]      miss_way_i;

  logic                  mem_req_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_gnt_i;
  logic                  mem_rvld_i;
  logic [31:0]           mem_rdat_i;
  logic                  mem_err_i;

  logic                  scan_enb_o;
  logic [8:0]            scan_addr_o;
  logic [31:0]           scan_data_o;
  logic [NUM_WAYS-1:0]   scan_web_tag_o;
  logic [NUM_WAYS-1:0]   scan_web_cache_o;
  logic                  scan_web_meta_o;

  logic                  fwd_vld_o;
  logic [31:0]           fwd_dat_o;

  logic                  done_vld_o;
  logic                  done_err_o;
  logic                  done_rdy_i;

  // Refill engine side
  modport master (
    input  miss_vld_i, miss_addr_i, miss_way_i,
    output miss_rdy_o,
    output mem_req_o, mem_addr_o,
    input  mem_gnt_i, mem_rvld_i, mem_rdat_i, mem_err_i,
    output scan_enb_o, scan_addr_o, scan_data_o,
    output scan_web_tag_o, scan_web_cache_o, scan_web_meta_o,
    output fwd_vld_o, fwd_dat_o,
    output done_vld_o, done_err_o,
    input  done_rdy_i
  );

  // Cache controller / memory side
  modport slave (
    output miss_vld_i, miss_addr_i, miss_way_i,
    input  miss_rdy_o,
    input  mem_req_o, mem_addr_o,
    output mem_gnt_i, mem_rvld_i, mem_rdat_i, mem_err_i,
    input  scan_enb_o, scan_addr_o, scan_data_o,
    input  scan_web_tag_o, scan_web_cache_o, scan_web_meta_o,
    input  fwd_vld_o, fwd_dat_o,
    input  done_vld_o, done_err_o,
    output done_rdy_i
  );
endinterface

// File: rtl/cache_refill.sv
// Line-refill engine: fetches a 4-word line, writes data words then the tag, forwards the critical word.
module cache_refill #(
  parameter int unsigned ADDR_WIDTH = 30,
  parameter int unsigned NUM_WAYS   = 4
) (
  input logic            clk,
  input logic            reset,
  cache_refill_if.master bus
);
  localparam int unsigned TAG_W = ADDR_WIDTH - 9;
  localparam int unsigned WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [2:0] {IDLE, REQ, DATA, TAG, DONE} state_t;

  state_t              state_q;
  logic [1:0]          off_q;
  logic [1:0]          cnt_q;
  logic [WAY_W-1:0]    way_q;
  logic                err_q;
  logic                last_q;

  logic [6:0]          index_c;
  logic [TAG_W-1:0]    tag_c;
  logic [NUM_WAYS-1:0] way_sel_c;
  logic [31:0]         tag_word_c;

  // Line fields come from the captured, line-aligned request address
  assign index_c   = bus.mem_addr_o[8:2];
  assign tag_c     = bus.mem_addr_o[ADDR_WIDTH-1:9];
  assign way_sel_c = NUM_WAYS'(1) << way_q;

  // Tag entry: valid bit cleared when any beat reported an error
  always_comb begin
    tag_word_c            = '0;
    tag_word_c[31]        = ~err_q;
    tag_word_c[TAG_W-1:0] = tag_c;
  end

  assign bus.miss_rdy_o      = (state_q == IDLE);
  assign bus.scan_web_meta_o = 1'b1;

  // Refill sequencer with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q              <= IDLE;
      off_q                <= '0;
      cnt_q                <= '0;
      way_q                <= '0;
      err_q                <= 1'b0;
      last_q               <= 1'b0;
      bus.mem_req_o        <= 1'b0;
      bus.mem_addr_o       <= '0;
      bus.scan_enb_o       <= 1'b1;
      bus.scan_addr_o      <= '0;
      bus.scan_data_o      <= '0;
      bus.scan_web_tag_o   <= '1;
      bus.scan_web_cache_o <= '1;
      bus.fwd_vld_o        <= 1'b0;
      bus.fwd_dat_o        <= '0;
      bus.done_vld_o       <= 1'b0;
      bus.done_err_o       <= 1'b0;
    end else begin
      bus.fwd_vld_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.miss_vld_i) begin
            bus.mem_addr_o <= {bus.miss_addr_i[ADDR_WIDTH-1:2], 2'b00};
            off_q          <= bus.miss_addr_i[1:0];
            way_q          <= bus.miss_way_i;
            cnt_q          <= '0;
            err_q          <= 1'b0;
            last_q         <= 1'b0;
            bus.mem_req_o  <= 1'b1;
            state_q        <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_gnt_i) begin
            bus.mem_req_o <= 1'b0;
            state_q       <= DATA;
          end
        end
        DATA: begin
          if (last_q) begin
            // Data complete: tag write keeps the SRAM port owned
            bus.scan_addr_o      <= {2'b00, index_c};
            bus.scan_data_o      <= tag_word_c;
            bus.scan_web_cache_o <= '1;
            bus.scan_web_tag_o   <= ~way_sel_c;
            state_q              <= TAG;
          end else if (bus.mem_rvld_i) begin
            bus.scan_enb_o       <= 1'b0;
            bus.scan_addr_o      <= {index_c, cnt_q};
            bus.scan_data_o      <= bus.mem_rdat_i;
            bus.scan_web_cache_o <= ~way_sel_c;
            bus.fwd_vld_o        <= (cnt_q == off_q);
            if (cnt_q == off_q) bus.fwd_dat_o <= bus.mem_rdat_i;
            if (bus.mem_err_i) err_q <= 1'b1;
            if (cnt_q == 2'd3) last_q <= 1'b1;
            else               cnt_q  <= cnt_q + 2'd1;
          end else begin
            // Gap between beats: hold the port, write nothing
            bus.scan_web_cache_o <= '1;
          end
        end
        TAG: begin
          bus.scan_enb_o     <= 1'b1;
          bus.scan_web_tag_o <= '1;
          bus.done_vld_o     <= 1'b1;
          bus.done_err_o     <= err_q;
          state_q            <= DONE;
        end
        DONE: begin
          if (bus.done_rdy_i) begin
            bus.done_vld_o <= 1'b0;
            bus.done_err_o <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/cache_refill.md
# cache_refill

Line-refill engine sitting directly downstream of `cache_ctrl` on the miss path. It accepts a miss (word address plus victim way), fetches the 4-word line from external memory in a burst, writes the data words and then the tag into the cache SRAMs through the SRAM scan/write port, and forwards the critical word. The tag is written last, so a line never appears valid before all of its data has landed.

## Interface
- `ADDR_WIDTH`, 30: word-address width. Tag width is `ADDR_WIDTH-9` (21 at the default).
- `NUM_WAYS`, 4: number of ways. Fixed geometry is 128 sets × 4 words per line.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `miss_vld_i`  in  1  miss request valid.
- `miss_rdy_o`  out  1  engine idle and able to accept a miss.
- `miss_addr_i`  in  ADDR_WIDTH  missing word address: `[1:0]` offset, `[8:2]` index, `[ADDR_WIDTH-1:9]` tag.
- `miss_way_i`  in  $clog2(NUM_WAYS)  victim way.
- `mem_req_o`  out  1  burst read request.
- `mem_addr_o`  out  ADDR_WIDTH  line-aligned address (`miss_addr` with offset bits zeroed).
- `mem_gnt_i`  in  1  request accepted.
- `mem_rvld_i`  in  1  read beat valid.
- `mem_rdat_i`  in  32  read beat data.
- `mem_err_i`  in  1  beat error; qualified by `mem_rvld_i`.
- `scan_enb_o`  out  1  SRAM port select. 0 = this engine owns the SRAM port; 1 = `cache_ctrl` owns it.
- `scan_addr_o`  out  9  SRAM address.
- `scan_data_o`  out  32  SRAM write data.
- `scan_web_tag_o`  out  NUM_WAYS  per-way tag write enable, active-low.
- `scan_web_cache_o`  out  NUM_WAYS  per-way data write enable, active-low.
- `scan_web_meta_o`  out  1  meta write enable, active-low; always 1.
- `fwd_vld_o`  out  1  one-cycle pulse: critical word valid.
- `fwd_dat_o`  out  32  critical word.
- `done_vld_o`  out  1  refill complete.
- `done_err_o`  out  1  refill aborted by a memory error; valid while `done_vld_o` is high.
- `done_rdy_i`  in  1  completion acknowledged.

## Operation
- FSM states: IDLE, REQ, DATA, TAG, DONE.
- **IDLE**
  - `miss_rdy_o=1`.
  - On `miss_vld_i` high, capture address and way, clear the beat counter and error flag, then go to REQ.
- **REQ**
  - `mem_req_o=1` with `mem_addr_o` stable.
  - Hold until `mem_gnt_i` is high, then go to DATA.
- **DATA**
  - Each `mem_rvld_i` beat `k` (2-bit counter, 0..3) is registered.
  - One cycle later, drive `scan_enb_o=0`, `scan_addr_o={index,k}`, `scan_data_o=beat`, and pull `scan_web_cache_o[way]` low. All other web bits stay high.
  - If `k` equals the captured offset, pulse `fwd_vld_o` with the beat data. This pulse is coincident with the SRAM write.
  - If `mem_err_i` is high on a beat, set the error flag. The beat is still written; the line is invalidated at tag time.
  - After beat 3 is written, go to TAG. The counter is not allowed to wrap.
  - Beats arriving in IDLE, REQ, TAG or DONE are ignored.
- **TAG**
  - One cycle: `scan_enb_o=0`, `scan_addr_o={2'b0,index}`, `scan_web_tag_o[way]=0`.
  - `scan_data_o = {~err, 10'b0, tag[20:0]}`.
  - Then go to DONE.
- **DONE**
  - `scan_enb_o=1`, all web bits high.
  - `done_vld_o=1` and `done_err_o=err`, held until `done_rdy_i` is high, then go to IDLE.
- `scan_enb_o` stays 0 continuously from the first data write through the TAG cycle. `cache_ctrl` is stalled by its own miss for that whole window.
- Ownership:
  - `scan_web_meta_o` is tied to 1; LRU/meta updates belong to `cache_ctrl`.
  - `scan_enb_o` is 1 in every state except DATA write cycles and TAG.
  - Way index is decoded one-hot into the web vectors.

## Timing
- Reset values (asynchronous, while `reset=0`):
  - state IDLE
  - `miss_rdy_o=1`
  - `mem_req_o=0`, `mem_addr_o=0`
  - `scan_enb_o=1`, `scan_addr_o=0`, `scan_data_o=0`
  - `scan_web_tag_o` and `scan_web_cache_o` all 1s; `scan_web_meta_o=1`
  - `fwd_vld_o=0`, `fwd_dat_o=0`
  - `done_vld_o=0`, `done_err_o=0`
- All outputs are registered, except `miss_rdy_o`, which is decoded from state.
- Accept at cycle 0 → `mem_req_o` high at cycle 1.
- Grant at cycle g → beats are accepted from cycle g+1.
- Beat at cycle t → SRAM write and any `fwd_vld_o` pulse at t+1.
- Last data write at cycle w → tag write at w+1 → `done_vld_o` at w+2.
- Best case, accept to done: 8 cycles (grant at cycle 1, back-to-back beats from cycle 2).
- Gaps between beats are allowed. The write is simply delayed; no data is lost.
- `miss_vld_i` is not sampled outside IDLE.
- `done_rdy_i` high in the same cycle `done_vld_o` rises → return to IDLE on the next edge.
- Reset mid-refill:
  - Immediate return to IDLE with all outputs at reset values.
  - The tag has not been written, so the partially filled line stays invalid.
  - A stale in-flight `mem_rvld_i` after reset is ignored.

## Test plan
- **Clean refill.** Miss addr=0x0000_0A06 (tag=5, index=1, offset=2), way=2, grant in cycle 1, beats 0xA0..0xA3 back-to-back.
  - Data writes to `scan_addr` 0x004..0x007 with `scan_web_cache_o`=4'b1011.
  - `fwd_dat_o`=0xA2.
  - Tag write at addr 0x001 with data 0x8000_0005 and `scan_web_tag_o`=4'b1011.
  - `done_vld_o` 8 cycles after accept, with `done_err_o`=0.
- **Stalled grant and gaps.** `mem_gnt_i` delayed 5 cycles; 2 idle cycles between each beat.
  - Writes keep the 1-cycle-after-beat timing and stay in order.
  - `mem_req_o` held continuously until grant.
- **Error beat.** `mem_err_i` high on beat 1.
  - All 4 data writes still occur.
  - Tag data = 0x0000_0005 (valid=0).
  - `done_err_o`=1.
- **Offset 3, way 0.**
  - `fwd_vld_o` pulses only on the beat-3 write.
  - `scan_web_cache_o`=4'b1110.
  - `mem_addr_o` has bits [1:0]=0.
- **Reset after beat 2.** Pull `reset` low, then release.
  - Outputs return to reset values immediately.
  - No tag write occurs.
  - Late beats are ignored.
  - `miss_rdy_o`=1.
- **Backpressured done.** Hold `done_rdy_i`=0 for 10 cycles.
  - `done_vld_o` stays high for the whole hold.
  - `miss_vld_i` is ignored (`miss_rdy_o`=0).
  - After `done_rdy_i`=1, `miss_rdy_o`=1 on the next cycle.
